int_to_f32_convert_sched: RTL
=============================

# int_to_f32_convert_sched

Two-requester scheduler and pipeline wrapper around the shared int32/uint32-to-recoded-float32 rounding datapath in the FPU integer-move path. It arbitrates round-robin between two issue ports and normalizes the 32-bit integer with a leading-zero count and left shift. It then rounds to recoded float32 (33 bits) and returns results with tag, source ID and exception flags over a valid/ready handshake. Throughput is one conversion per cycle; latency is 2 cycles.

## Interface
- No parameters; widths are fixed to int32 in and recoded float32 out.
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  port accepted this cycle when valid&ready
- req0_data / req1_data  in  32  integer operand
- req0_signed / req1_signed  in  1  1 = two's-complement int32, 0 = uint32
- req0_rm / req1_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 6 round-to-odd; 5 and 7 are treated as RNE
- req0_tag / req1_tag  in  5  destination tag, returned unchanged
- flush  in  1  discard all in-flight conversions
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  33  recoded float32 {sign, exp[8:0], fract[22:0]}
- resp_flags  out  5  {NV,DZ,OF,UF,NX}; only NX can be set
- resp_tag  out  5  tag of the result
- resp_src  out  1  requester that issued the result
- busy  out  1  s1_valid | s2_valid

## Operation
- Arbiter: a 1-bit priority pointer `prio` names the preferred port.
  - If only one port is valid, that port is granted.
  - If both are valid, port `prio` is granted.
  - `prio` updates to ~granted_port only on an accepted transfer. An idle cycle or a stalled grant does not move it.
- reqN_ready = grant_N & s1_load & ~flush. A port that is not granted sees ready=0 even if the pipe can load.
- Normalize, combinational before S1:
  - Compute sign and magnitude (signed with data[31] set: magnitude = -data, sign = 1; otherwise sign = 0).
  - Take lzc of the magnitude over 32 bits, then norm = magnitude << lzc.
  - Unbiased exponent e = 31 - lzc.
  - isZero = (magnitude == 0).
- S1 register holds {norm[31:0], e[4:0], sign, isZero, rm, tag, src}.
- Round, combinational between S1 and S2:
  - Keep 24 significand bits norm[31:8]. Round on guard bit norm[7] and sticky bit |norm[6:0] per rm.
  - RDN and RUP use the sign. RMM breaks ties away from zero. Round-to-odd forces LSB=1 when inexact.
  - Carry-out renormalizes: exponent +1, fraction becomes 0.
  - Recoded exponent = e + 9'h100 (+1 on carry). Overflow is impossible.
  - isZero gives resp_data = 33'h0 (+0) with flags 0.
  - NX = guard | sticky.
- Handshake and stall rules:
  - s2_load = ~s2_valid | resp_ready.
  - s1_load = ~s1_valid | s2_load.
  - Each stage holds contents and valid when it cannot load.
- Flush:
  - Synchronously clears s1_valid and s2_valid.
  - Forces both reqN_ready = 0 that cycle.
  - Leaves `prio` unchanged.
  - A flush coincident with a resp handshake still counts the handshake as delivered.
- Reset:
  - s1_valid = s2_valid = 0 and prio = 0.
  - resp_data, resp_flags, resp_tag and resp_src = 0.
  - resp_valid, busy and reqN_ready read 0 during reset.

## Timing
- Accept at edge t: S1 is valid after t. Result is registered in S2 at edge t+1, so resp_valid is high in cycle t+1 (2 cycles after request presentation).
- Back-to-back accepts sustain 1 result per cycle while resp_ready = 1.
- Holding resp_ready=0:
  - Fills S2, then S1.
  - The third request sees ready=0.
  - Output payload stays stable while resp_valid=1 and resp_ready=0.
- reqN_ready depends combinationally on resp_ready, flush and the other port's valid. There is no combinational path from req data to resp.

## Test plan
- Single request: port 0 uint32 1, RNE, tag 3 -> 2 cycles later resp_data=33'h080000000, flags 0, tag 3, src 0.
- Rounding:
  - uint32 32'hFFFFFFFF, RNE -> 33'h090000000, NX=1.
  - Same operand, RTZ -> 33'h08FFFFFFF, NX=1.
- Signed edge cases:
  - int32 32'h80000000 -> 33'h18F800000, exact.
  - int32 -1 -> 33'h180000000.
  - 0 -> 33'h000000000.
- Arbitration fairness: both ports valid for 6 cycles, resp_ready=1 -> grants alternate 0,1,0,1,0,1; resp_src follows the same order.
- Backpressure: 4 back-to-back requests with resp_ready=0 for 5 cycles -> 2 held in pipe, third sees ready=0, no loss or reorder after release, and the held output stays stable.
- Flush and reset: flush with 2 in flight -> busy=0 next cycle, no responses emitted. Reset mid-stream -> all outputs 0 and prio=0.

Source files
------------

// File: rtl/int_to_f32_convert_sched.sv
// Two-port round-robin scheduler around a 2-stage int32/uint32 to
// recoded float32 converter (normalize -> S1 -> round -> S2).
module int_to_f32_convert_sched (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic        req0_signed,
    input  logic [2:0]  req0_rm,
    input  logic [4:0]  req0_tag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_signed,
    input  logic [2:0]  req1_rm,
    input  logic [4:0]  req1_tag,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [32:0] resp_data,
    output logic [4:0]  resp_flags,
    output logic [4:0]  resp_tag,
    output logic        resp_src,
    output logic        busy
);
    logic        r_prio;
    logic        r_s1_valid;
    logic [30:0] r_s1_norm;
    logic [4:0]  r_s1_exp;
    logic        r_s1_sign;
    logic        r_s1_zero;
    logic [2:0]  r_s1_rm;
    logic [4:0]  r_s1_tag;
    logic        r_s1_src;
    logic        r_s2_valid;
    logic [32:0] r_s2_data;
    logic [4:0]  r_s2_flags;
    logic [4:0]  r_s2_tag;
    logic        r_s2_src;

    logic        w_s2_load, w_s1_load, w_take, w_accept;
    logic        w_grant0, w_grant1;
    logic [31:0] w_data, w_mag, w_norm;
    logic        w_sgn, w_neg;
    logic [2:0]  w_rm;
    logic [4:0]  w_tag, w_lzc;
    logic        w_g, w_st, w_lsb, w_nx, w_inc;
    logic [23:0] w_sum;
    logic [22:0] w_fract;
    logic [8:0]  w_rexp;
    logic [32:0] w_res;

    assign w_s2_load = ~r_s2_valid | resp_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign w_take    = w_s1_load & ~flush & ~reset;
    assign w_grant0  = req0_valid & (~req1_valid | ~r_prio);
    assign w_grant1  = req1_valid & (~req0_valid | r_prio);
    assign req0_ready = w_grant0 & w_take;
    assign req1_ready = w_grant1 & w_take;
    assign w_accept  = req0_ready | req1_ready;

    assign w_data = w_grant1 ? req1_data   : req0_data;
    assign w_sgn  = w_grant1 ? req1_signed : req0_signed;
    assign w_rm   = w_grant1 ? req1_rm     : req0_rm;
    assign w_tag  = w_grant1 ? req1_tag    : req0_tag;
    assign w_neg  = w_sgn & w_data[31];
    assign w_mag  = w_neg ? (32'd0 - w_data) : w_data;

    always_comb begin
        w_lzc = 5'd0;
        for (int i = 0; i < 32; i++)
            if (w_mag[i]) w_lzc = 5'(31 - i);
    end

    // After normalization the top bit is set unless the operand is zero
    assign w_norm = w_mag << w_lzc;

    assign w_lsb = r_s1_norm[8];
    assign w_g   = r_s1_norm[7];
    assign w_st  = |r_s1_norm[6:0];
    assign w_nx  = w_g | w_st;

    always_comb begin
        w_inc = 1'b0;
        case (r_s1_rm)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = r_s1_sign & w_nx;
            3'd3:    w_inc = ~r_s1_sign & w_nx;
            3'd4:    w_inc = w_g;
            3'd6:    w_inc = 1'b0;
            default: w_inc = w_g & (w_st | w_lsb);
        endcase
    end

    // Carry out of the fraction means the significand rolled to 2.0
    assign w_sum   = {1'b0, r_s1_norm[30:8]} + {23'd0, w_inc};
    assign w_fract = w_sum[22:0]
                   | {22'd0, (r_s1_rm == 3'd6) & w_nx};
    assign w_rexp  = {4'b1000, r_s1_exp} + {8'd0, w_sum[23]};
    assign w_res   = r_s1_zero ? 33'd0
                   : {r_s1_sign, w_rexp, w_fract};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_norm  <= '0;
            r_s1_exp   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_rm    <= '0;
            r_s1_tag   <= '0;
            r_s1_src   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_flags <= '0;
            r_s2_tag   <= '0;
            r_s2_src   <= 1'b0;
        end else begin
            if (w_accept) r_prio <= ~w_grant1;
            if (flush) r_s1_valid <= 1'b0;
            else if (w_s1_load) r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_norm <= w_norm[30:0];
                r_s1_exp  <= ~w_lzc;
                r_s1_sign <= w_neg;
                r_s1_zero <= ~w_norm[31];
                r_s1_rm   <= w_rm;
                r_s1_tag  <= w_tag;
                r_s1_src  <= w_grant1;
            end
            if (flush) r_s2_valid <= 1'b0;
            else if (w_s2_load) r_s2_valid <= r_s1_valid;
            if (w_s2_load & r_s1_valid) begin
                r_s2_data  <= w_res;
                r_s2_flags <= {4'd0, w_nx & ~r_s1_zero};
                r_s2_tag   <= r_s1_tag;
                r_s2_src   <= r_s1_src;
            end
        end
    end

    assign resp_valid = r_s2_valid & ~reset;
    assign busy       = (r_s1_valid | r_s2_valid) & ~reset;
    assign resp_data  = r_s2_data;
    assign resp_flags = r_s2_flags;
    assign resp_tag   = r_s2_tag;
    assign resp_src   = r_s2_src;
endmodule
